// File: rtl/tenv_clkctrl.sv
// -----------------------------------------------------------------------------
// tenv_clkctrl
//
// Command-driven controller for CLOCKS_NUMBER clock-generator channels. Each
// channel has a registered enable, an initial level and a pair of 32-bit
// high/low times. One command is handled at a time through a valid/ready
// handshake, and every command ends with a one-cycle cmd_done pulse. cmd_err
// accompanies cmd_done when the command was rejected.
//
// Changing the times of a running channel is a "live retime":
//   1. The channel is stopped.
//   2. The block waits SETTLE_CYCLES cycles.
//   3. The new times are loaded and the channel is restarted on the same edge.
// As a result, en[ch] is low for exactly SETTLE_CYCLES+1 cycles.
//
// Ports
//   clk        in   block clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   cmd_valid  in   command present
//   cmd_ready  out  high only in IDLE; accept = cmd_valid & cmd_ready
//   cmd_op     in   00 DISABLE, 01 ENABLE, 10 SET_TIMES, 11 SET_INIT
//   cmd_ch     in   target channel
//   cmd_high   in   new high time (SET_TIMES) / bit 0 = init level (SET_INIT)
//   cmd_low    in   new low time (SET_TIMES)
//   cmd_done   out  one-cycle completion pulse
//   cmd_err    out  one-cycle rejection pulse, only together with cmd_done
//   init       out  per-channel initial level
//   en         out  per-channel enable
//   time_high  out  per-channel high time, lane i at [(i+1)*32-1:i*32]
//   time_low   out  per-channel low time, same lane packing
// -----------------------------------------------------------------------------
module tenv_clkctrl #(
  parameter int CLOCKS_NUMBER = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int DEFAULT_TIME  = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [7:0]                   cmd_ch,
  input  logic [31:0]                  cmd_high,
  input  logic [31:0]                  cmd_low,
  output logic                         cmd_done,
  output logic                         cmd_err,
  output logic [CLOCKS_NUMBER-1:0]     init,
  output logic [CLOCKS_NUMBER-1:0]     en,
  output logic [CLOCKS_NUMBER*32-1:0]  time_high,
  output logic [CLOCKS_NUMBER*32-1:0]  time_low
);

  typedef enum logic [1:0] {
    OP_DISABLE   = 2'b00,
    OP_ENABLE    = 2'b01,
    OP_SET_TIMES = 2'b10,
    OP_SET_INIT  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_DROP,
    S_SETTLE,
    S_LOAD
  } state_t;

  localparam logic [CLOCKS_NUMBER*32-1:0] LANES_RESET = {CLOCKS_NUMBER{32'(DEFAULT_TIME)}};
  localparam logic [7:0]                  SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t                        r_state;
  state_t                        w_next;
  logic                          r_err;
  logic [7:0]                    r_ch;
  logic [31:0]                   r_high;
  logic [31:0]                   r_low;
  logic [7:0]                    r_cnt;
  logic [CLOCKS_NUMBER-1:0]      r_en;
  logic [CLOCKS_NUMBER-1:0]      r_init;
  logic [CLOCKS_NUMBER*32-1:0]   r_time_high;
  logic [CLOCKS_NUMBER*32-1:0]   r_time_low;

  op_t  w_op;
  int   w_ch_idx;
  int   r_ch_idx;
  logic w_ch_ok;
  logic w_ch_en;
  logic w_err;
  logic w_live;
  logic w_accept;
  logic w_load;

  assign w_op     = op_t'(cmd_op);
  assign w_ch_idx = int'({24'd0, cmd_ch});
  assign r_ch_idx = int'({24'd0, r_ch});
  assign w_ch_ok  = (w_ch_idx < CLOCKS_NUMBER);

  // The new times are loaded on the edge that leaves the last SETTLE cycle.
  // That same edge restarts the channel, so cmd_done in the LOAD cycle
  // coincides with the first cycle that en is high again.
  assign w_load = (r_state == S_SETTLE) && (r_cnt == 8'd0);

  // Validation looks at the live cmd_* inputs, because it is evaluated in the
  // accepting cycle itself.
  always_comb begin
    // NOTE: every always_comb output is given a default before any branch, so
    // no path can leave it unassigned and infer a latch.
    w_ch_en = 1'b0;
    for (int i = 0; i < CLOCKS_NUMBER; i++) begin
      if (w_ch_idx == i) w_ch_en = r_en[i];
    end
    w_err  = !w_ch_ok
          || ((w_op == OP_SET_TIMES) && ((cmd_high == 32'd0) || (cmd_low == 32'd0)))
          || ((w_op == OP_SET_INIT) && w_ch_en);
    w_live = !w_err && (w_op == OP_SET_TIMES) && w_ch_en;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM: next state and handshake outputs
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    cmd_ready = 1'b0;
    cmd_done  = 1'b0;
    cmd_err   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_accept = 1'b1;
          w_next   = w_live ? S_DROP : S_EXEC;
        end
      end
      S_EXEC: begin
        cmd_done = 1'b1;
        cmd_err  = r_err;
        w_next   = S_IDLE;
      end
      S_DROP:   w_next = S_SETTLE;
      S_SETTLE: if (r_cnt == 8'd0) w_next = S_LOAD;
      S_LOAD: begin
        cmd_done = 1'b1;
        w_next   = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath: command latch, settle counter, per-channel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the lane registers are ordinary flops and not a RAM, so all of
    // them take DEFAULT_TIME in the reset branch.
    if (!rst_n) begin
      r_err       <= 1'b0;
      r_ch        <= 8'd0;
      r_high      <= 32'd0;
      r_low       <= 32'd0;
      r_cnt       <= 8'd0;
      r_en        <= '0;
      r_init      <= '0;
      r_time_high <= LANES_RESET;
      r_time_low  <= LANES_RESET;
    end else begin
      // NOTE: state is updated with non-blocking assignments. Every read in
      // this block therefore sees the pre-edge value, whatever the
      // statement order.
      if (w_accept) begin
        r_err  <= w_err;
        r_ch   <= cmd_ch;
        r_high <= cmd_high;
        r_low  <= cmd_low;
      end

      // The counter is reloaded while in DROP, so each SETTLE entry starts
      // fresh. It then counts down and holds at zero instead of wrapping.
      if (r_state == S_DROP) begin
        r_cnt <= SETTLE_LOAD;
      end else if ((r_state == S_SETTLE) && (r_cnt != 8'd0)) begin
        r_cnt <= r_cnt - 8'd1;
      end

      for (int i = 0; i < CLOCKS_NUMBER; i++) begin
        if (w_accept && !w_err && (w_ch_idx == i)) begin
          unique case (w_op)
            OP_DISABLE: r_en[i] <= 1'b0;
            OP_ENABLE:  r_en[i] <= 1'b1;
            OP_SET_INIT: r_init[i] <= cmd_high[0];
            OP_SET_TIMES: begin
              if (w_ch_en) begin
                r_en[i] <= 1'b0;                  // live retime: stop first
              end else begin
                r_time_high[i*32 +: 32] <= cmd_high;
                r_time_low[i*32 +: 32]  <= cmd_low;
              end
            end
            default: ;
          endcase
        end
        if (w_load && (r_ch_idx == i)) begin
          r_time_high[i*32 +: 32] <= r_high;
          r_time_low[i*32 +: 32]  <= r_low;
          r_en[i]                 <= 1'b1;
        end
      end
    end
  end

  assign en        = r_en;
  assign init      = r_init;
  assign time_high = r_time_high;
  assign time_low  = r_time_low;

endmodule

// File: tb/tb_tenv_clkctrl.sv
// -----------------------------------------------------------------------------
// tb_tenv_clkctrl
//
// Scoreboard bench for tenv_clkctrl with CLOCKS_NUMBER=2, SETTLE_CYCLES=4 and
// DEFAULT_TIME=5.
//
// Each time the driver issues a command, a channel-level reference model
// predicts the result and pushes it onto a queue. That prediction covers:
//   - the error flag,
//   - the complete output snapshot,
//   - the latency from acceptance to cmd_done.
//
// A separate monitor pops one entry on every cmd_done and compares it with
// the DUT. For live retimes it also checks how long the en bit stayed low.
// -----------------------------------------------------------------------------
module tb_tenv_clkctrl;

  localparam int CH = 2;
  localparam int S  = 4;
  localparam int DT = 5;

  localparam bit [1:0] OP_DIS  = 2'b00;
  localparam bit [1:0] OP_ENA  = 2'b01;
  localparam bit [1:0] OP_TIME = 2'b10;
  localparam bit [1:0] OP_INIT = 2'b11;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [1:0]     cmd_op = 2'b00;
  logic [7:0]     cmd_ch = 8'd0;
  logic [31:0]    cmd_high = 32'd0;
  logic [31:0]    cmd_low = 32'd0;
  logic           cmd_done;
  logic           cmd_err;
  logic [CH-1:0]  init;
  logic [CH-1:0]  en;
  logic [CH*32-1:0] time_high;
  logic [CH*32-1:0] time_low;

  tenv_clkctrl #(
    .CLOCKS_NUMBER (CH),
    .SETTLE_CYCLES (S),
    .DEFAULT_TIME  (DT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_ch    (cmd_ch),
    .cmd_high  (cmd_high),
    .cmd_low   (cmd_low),
    .cmd_done  (cmd_done),
    .cmd_err   (cmd_err),
    .init      (init),
    .en        (en),
    .time_high (time_high),
    .time_low  (time_low)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit        err;
    bit        live;
    int        ch;
    bit [1:0]  en;
    bit [1:0]  init;
    bit [63:0] th;
    bit [63:0] tl;
    int        acc;
  } exp_t;

  exp_t q[$];

  // Reference model: channel-level state.
  bit        m_en[CH];
  bit        m_init[CH];
  bit [31:0] m_th[CH];
  bit [31:0] m_tl[CH];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_en[i]   = 1'b0;
      m_init[i] = 1'b0;
      m_th[i]   = 32'(DT);
      m_tl[i]   = 32'(DT);
    end
  endtask

  // Issue one command, keeping cmd_valid high until the DUT accepts it.
  // Call this about 1 time unit after a rising edge. It returns about
  // 1 time unit after the accepting edge.
  task automatic send(input bit [1:0] op, input bit [7:0] ch, input bit [31:0] hi,
                      input bit [31:0] lo, output int acc, output bit live,
                      output int waited);
    exp_t e;
    int   chi;
    chi      = int'(ch);
    acc      = -1;
    live     = 1'b0;
    waited   = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_ch    = ch;
    cmd_high  = hi;
    cmd_low   = lo;
    while (1) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) break;
      waited++;
      if (waited > 60) begin
        n_checks++;
        n_errors++;
        $display("FAIL accept_timeout: got no cmd_ready in %0d cycles, expected acceptance", waited);
        cmd_valid = 1'b0;
        return;
      end
    end
    // Acceptance happens at the coming edge. Predict the result now.
    e.err = (chi >= CH);
    if (chi < CH) begin
      if (op == OP_TIME && (hi == 0 || lo == 0)) e.err = 1'b1;
      if (op == OP_INIT && m_en[chi])            e.err = 1'b1;
    end
    e.live = !e.err && (op == OP_TIME) && m_en[chi];
    if (!e.err) begin
      case (op)
        OP_DIS:  m_en[chi] = 1'b0;
        OP_ENA:  m_en[chi] = 1'b1;
        OP_TIME: begin m_th[chi] = hi; m_tl[chi] = lo; end
        default: m_init[chi] = hi[0];
      endcase
    end
    e.ch   = chi;
    e.en   = {m_en[1], m_en[0]};
    e.init = {m_init[1], m_init[0]};
    e.th   = {m_th[1], m_th[0]};
    e.tl   = {m_tl[1], m_tl[0]};
    e.acc  = cyc + 1;
    q.push_back(e);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    acc  = cyc;
    live = e.live;
  endtask

  // Monitor: pop and compare on every cmd_done; also track en-low run lengths.
  initial begin
    int   low_run[CH];
    int   ended[CH];
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        for (int i = 0; i < CH; i++) low_run[i] = 0;
        continue;
      end
      for (int i = 0; i < CH; i++) begin
        ended[i] = 0;
        if (en[i] !== 1'b1) begin
          low_run[i]++;
        end else begin
          ended[i]   = low_run[i];
          low_run[i] = 0;
        end
      end
      if (cmd_err === 1'b1 && cmd_done !== 1'b1) begin
        n_checks++;
        n_errors++;
        $display("FAIL err_without_done: got cmd_err=1 cmd_done=%b, expected cmd_err only with cmd_done", cmd_done);
      end
      if (cmd_done === 1'b1) begin
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got cmd_done=1 at cycle %0d, expected no pending command", cyc);
        end else begin
          e = q.pop_front();
          check("done_err", 64'(cmd_err), 64'(e.err));
          check("done_en", 64'(en), 64'(e.en));
          check("done_init", 64'(init), 64'(e.init));
          check("done_time_high", time_high, e.th);
          check("done_time_low", time_low, e.tl);
          check("done_latency", 64'(cyc - e.acc), e.live ? 64'(S + 1) : 64'd0);
          if (e.live) check("retime_en_low_cycles", 64'(ended[e.ch]), 64'(S + 1));
        end
      end
    end
  end

  initial begin
    int acc[4];
    bit live[4];
    int a;
    bit l;
    int w;
    bit [1:0]  op;
    bit [7:0]  ch;
    bit [31:0] hi;
    bit [31:0] lo;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    // While in reset
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_done", 64'(cmd_done), 64'd0);
    check("rst_err", 64'(cmd_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_en", 64'(en), 64'd0);
    check("rel_init", 64'(init), 64'd0);
    check("rel_time_high", time_high, {32'(DT), 32'(DT)});
    check("rel_time_low", time_low, {32'(DT), 32'(DT)});
    check("rel_ready", 64'(cmd_ready), 64'd1);

    // Simple enable / disable of channel 1
    send(OP_ENA, 8'd1, 32'd0, 32'd0, a, l, w);
    send(OP_DIS, 8'd1, 32'd0, 32'd0, a, l, w);

    // Live retime of channel 0
    send(OP_ENA,  8'd0, 32'd0, 32'd0, a, l, w);
    send(OP_TIME, 8'd0, 32'd7, 32'd3, a, l, w);

    // Rejections, plus repeated enable as a valid no-op
    send(OP_TIME, 8'd0, 32'd9, 32'd0, a, l, w);
    send(OP_INIT, 8'd0, 32'd1, 32'd0, a, l, w);
    send(OP_ENA,  8'd2, 32'd0, 32'd0, a, l, w);
    send(OP_TIME, 8'd2, 32'd1, 32'd1, a, l, w);
    send(OP_ENA,  8'd0, 32'd0, 32'd0, a, l, w);

    // Abort a live retime during SETTLE
    send(OP_TIME, 8'd0, 32'd11, 32'd12, a, l, w);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_en", 64'(en), 64'd0);
    check("abort_time_high", time_high, {32'(DT), 32'(DT)});
    check("abort_time_low", time_low, {32'(DT), 32'(DT)});
    check("abort_done", 64'(cmd_done), 64'd0);
    check("abort_ready", 64'(cmd_ready), 64'd1);
    q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(OP_ENA, 8'd0, 32'd0, 32'd0, a, l, w);
    check("post_reset_accept_wait", 64'(w), 64'd0);

    // Back-to-back throughput with cmd_valid held high
    send(OP_TIME, 8'd0, 32'd20, 32'd30, acc[0], live[0], w);
    send(OP_ENA,  8'd1, 32'd0,  32'd0,  acc[1], live[1], w);
    send(OP_TIME, 8'd1, 32'd40, 32'd50, acc[2], live[2], w);
    send(OP_DIS,  8'd0, 32'd0,  32'd0,  acc[3], live[3], w);
    for (int k = 1; k < 4; k++) begin
      check("accept_spacing", 64'(acc[k] - acc[k-1]), live[k-1] ? 64'(S + 3) : 64'd2);
    end

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(0, 3));
      ch = ($urandom_range(0, 9) == 0) ? 8'd200 : 8'($urandom_range(0, 2));
      hi = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom_range(1, 1000);
      lo = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom_range(1, 1000);
      send(op, ch, hi, lo, a, l, w);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    // Drain outstanding completions
    for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d pending completions, expected 0", q.size());
    end
    @(negedge clk);
    check("final_en", 64'(en), 64'({m_en[1], m_en[0]}));
    check("final_time_high", time_high, {m_th[1], m_th[0]});
    check("final_ready", 64'(cmd_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
